alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer_pkg.sv | 17 +
 rtl/alu_op_sequencer_if.sv | 15 +
 rtl/alu_op_sequencer_rr_arbiter.sv | 15 +
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// alu_pkg: opcode map, FSM states and default widths shared by the ALU op sequencer.
package alu_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_OP_W = 4;
  localparam int NUM_OPS = 10;
  localparam logic [3:0] OP_NEG_A = 4'd0;
  localparam logic [3:0] OP_NEG_B = 4'd1;
  localparam logic [3:0] OP_ROR_A = 4'd2;
  localparam logic [3:0] OP_ROR_B = 4'd3;
  localparam logic [3:0] OP_LT = 4'd4;
  localparam logic [3:0] OP_BITWISE = 4'd5;
  localparam logic [3:0] OP_NOT_A = 4'd6;
  localparam logic [3:0] OP_NOT_B = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8;
  localparam logic [3:0] OP_ADD = 4'd9;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU and response signals of the ALU op sequencer.
interface alu_op_sequencer_if import alu_pkg::*; #(parameter int WIDTH = DEF_WIDTH, parameter int OP_W = DEF_OP_W);
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [OP_W-1:0] req0_op, req1_op, alu_select;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_x, rsp_x;
  logic rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_neg, rsp_err, busy;
  modport slave (
    input req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, alu_x, rsp_ready,
    output req0_ready, req1_ready, alu_select, alu_a, alu_b, rsp_valid, rsp_id, rsp_x, rsp_zero, rsp_neg, rsp_err, busy
  );
  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, alu_x, rsp_ready,
    input req0_ready, req1_ready, alu_select, alu_a, alu_b, rsp_valid, rsp_id, rsp_x, rsp_zero, rsp_neg, rsp_err, busy
  );
endinterface

// File: rtl/alu_op_sequencer_rr_arbiter.sv
// alu_rr_arbiter: 2-way round-robin arbiter; pointer moves to the loser on advance.
module alu_rr_arbiter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  assign gnt = &req ? (ptr_q ? 2'b10 : 2'b01) : req;
  always_comb ptr_d = advance ? gnt[0] : ptr_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: shares the ALU between two requesters, waits WAIT_CYCLES, returns result and flags.
// Define ALU_OP_CHECK_EN to reject opcodes >= NUM_OPS without ever driving them to the ALU.
module alu_op_sequencer import alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OP_W = DEF_OP_W,
  parameter int WAIT_CYCLES = 1
) (
  input logic clk,
  input logic reset_n,
  alu_op_sequencer_if.slave bus
);
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 1..15");
  end
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [OP_W-1:0] sel_q, sel_d, op;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, x_q, x_d;
  logic id_q, id_d, vld_q, vld_d, zero_q, zero_d, neg_q, neg_d, err_q, err_d;
  logic [1:0] gnt;
  logic idle, fire, ill;
  assign idle = state_q == IDLE;
  assign fire = idle && |gnt;
  assign op = gnt[1] ? bus.req1_op : bus.req0_op;
`ifdef ALU_OP_CHECK_EN
  assign ill = int'(op) >= NUM_OPS;
`else
  assign ill = 1'b0;
`endif
  alu_rr_arbiter u_arb (
    .clk(clk),
    .reset_n(reset_n),
    .req({bus.req1_valid, bus.req0_valid}),
    .advance(fire),
    .gnt(gnt)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    a_d = a_q;
    b_d = b_q;
    id_d = id_q;
    vld_d = vld_q;
    x_d = x_q;
    zero_d = zero_q;
    neg_d = neg_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (fire) begin
        id_d = gnt[1];
        if (ill) begin
          state_d = RESP;
          vld_d = 1'b1;
          x_d = '0;
          zero_d = 1'b0;
          neg_d = 1'b0;
          err_d = 1'b1;
        end else begin
          state_d = EXEC;
          sel_d = op;
          a_d = gnt[1] ? bus.req1_a : bus.req0_a;
          b_d = gnt[1] ? bus.req1_b : bus.req0_b;
          cnt_d = 4'(WAIT_CYCLES - 1);
        end
      end
      EXEC: if (cnt_q == 4'd0) begin
        state_d = RESP;
        vld_d = 1'b1;
        x_d = bus.alu_x;
        zero_d = bus.alu_x == '0;
        neg_d = bus.alu_x[WIDTH-1];
        err_d = 1'b0;
      end else cnt_d = cnt_q - 4'd1;
      RESP: if (bus.rsp_ready) begin
        state_d = IDLE;
        vld_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sel_q <= '0;
      a_q <= '0;
      b_q <= '0;
      id_q <= 1'b0;
      vld_q <= 1'b0;
      x_q <= '0;
      zero_q <= 1'b0;
      neg_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      a_q <= a_d;
      b_q <= b_d;
      id_q <= id_d;
      vld_q <= vld_d;
      x_q <= x_d;
      zero_q <= zero_d;
      neg_q <= neg_d;
      err_q <= err_d;
    end
  assign bus.req0_ready = idle && gnt[0];
  assign bus.req1_ready = idle && gnt[1];
  assign bus.alu_select = sel_q;
  assign bus.alu_a = a_q;
  assign bus.alu_b = b_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_id = id_q;
  assign bus.rsp_x = x_q;
  assign bus.rsp_zero = zero_q;
  assign bus.rsp_neg = neg_q;
  assign bus.rsp_err = err_q;
  assign bus.busy = !idle;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: random scoreboard on a WAIT_CYCLES=1 instance, directed settle/reset checks on a WAIT_CYCLES=3 instance.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  always #5 clk = ~clk;
  alu_op_sequencer_if if0 ();
  alu_op_sequencer_if if1 ();
  alu_op_sequencer #(.WAIT_CYCLES(1)) u0 (.clk(clk), .reset_n(rst0_n), .bus(if0));
  alu_op_sequencer #(.WAIT_CYCLES(3)) u1 (.clk(clk), .reset_n(rst1_n), .bus(if1));
  int total = 0;
  int bad = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic timeout(string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask
  function automatic logic [7:0] alu_fn(logic [3:0] s, logic [7:0] a, logic [7:0] b);
    case (s)
      4'd0: return -a;
      4'd1: return -b;
      4'd2: return {a[0], a[7:1]};
      4'd3: return {b[0], b[7:1]};
      4'd4: return (a < b) ? 8'd1 : 8'd0;
      4'd5: return a & b;
      4'd6: return ~a;
      4'd7: return ~b;
      4'd8: return a - b;
      4'd9: return a + b;
      default: return a ^ b ^ 8'h5A;
    endcase
  endfunction
  assign if0.alu_x = alu_fn(if0.alu_select, if0.alu_a, if0.alu_b);
  // The second ALU only settles two edges after u1 starts its op; earlier samples see garbage.
  int set_cnt = 0;
  always @(posedge clk) set_cnt <= if1.busy ? set_cnt + 1 : 0;
  assign if1.alu_x = (set_cnt >= 2) ? alu_fn(if1.alu_select, if1.alu_a, if1.alu_b) : 8'hA5;
  typedef struct {
    logic id;
    logic [7:0] x;
    logic err;
    logic [3:0] sel;
  } exp_t;
  exp_t q[$];
  exp_t e;
  bit m_busy, m_valid, m_ptr, g0, g1, m_ill;
  int m_wait;
  logic [3:0] m_sel, m_op;
  logic [7:0] m_a, m_b;
  always @(negedge clk) begin
    if (!rst0_n) begin
      q.delete();
      m_busy = 0;
      m_valid = 0;
      m_ptr = 0;
      m_sel = 4'd0;
    end else begin
      chk("rsp_valid", if0.rsp_valid, m_valid);
      chk("busy", if0.busy, m_busy);
      g1 = !m_busy && if0.req1_valid && (!if0.req0_valid || m_ptr);
      g0 = !m_busy && if0.req0_valid && !g1;
      chk("req0_ready", if0.req0_ready, g0);
      chk("req1_ready", if0.req1_ready, g1);
      if (m_valid && q.size() > 0) begin
        chk("hold_x", if0.rsp_x, q[0].x);
        chk("hold_neg", if0.rsp_neg, q[0].x[7]);
      end
      if (m_valid && if0.rsp_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop: response with empty scoreboard");
        end else begin
          e = q.pop_front();
          chk("rsp_id", if0.rsp_id, e.id);
          chk("rsp_x", if0.rsp_x, e.x);
          chk("rsp_zero", if0.rsp_zero, e.x == 8'h00);
          chk("rsp_neg", if0.rsp_neg, e.x[7]);
          chk("rsp_err", if0.rsp_err, e.err);
          chk("alu_select", if0.alu_select, e.sel);
        end
        m_valid = 0;
        m_busy = 0;
      end else if (m_busy && !m_valid) begin
        m_wait--;
        if (m_wait == 0) m_valid = 1;
      end else if (g0 || g1) begin
        m_op = g1 ? if0.req1_op : if0.req0_op;
        m_a = g1 ? if0.req1_a : if0.req0_a;
        m_b = g1 ? if0.req1_b : if0.req0_b;
`ifdef ALU_OP_CHECK_EN
        m_ill = m_op >= 4'd10;
`else
        m_ill = 0;
`endif
        e.id = g1;
        m_ptr = !g1;
        m_busy = 1;
        if (m_ill) begin
          e.x = 8'h00;
          e.err = 1'b1;
          e.sel = m_sel;
          m_valid = 1;
        end else begin
          e.x = alu_fn(m_op, m_a, m_b);
          e.err = 1'b0;
          m_sel = m_op;
          e.sel = m_op;
          m_wait = 1;
        end
        q.push_back(e);
      end
    end
  end
  task automatic send0(bit id, logic [3:0] op, logic [7:0] a, logic [7:0] b);
    bit ok = 0;
    if (id) begin
      if0.req1_op = op; if0.req1_a = a; if0.req1_b = b; if0.req1_valid = 1;
    end else begin
      if0.req0_op = op; if0.req0_a = a; if0.req0_b = b; if0.req0_valid = 1;
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = id ? if0.req1_ready : if0.req0_ready;
    end
    if (!ok) timeout("send0");
    @(posedge clk);
    #1;
    if (id) if0.req1_valid = 0; else if0.req0_valid = 0;
  endtask
  task automatic wait_rsp1(output int lat);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (if1.rsp_valid) lat = i;
    end
    if (lat == 0) timeout("u1_rsp");
  endtask
  int lat;
  initial begin
    {if0.req0_valid, if0.req1_valid, if0.rsp_ready} = '0;
    {if0.req0_op, if0.req1_op, if0.req0_a, if0.req0_b, if0.req1_a, if0.req1_b} = '0;
    {if1.req0_valid, if1.req1_valid, if1.rsp_ready} = '0;
    {if1.req0_op, if1.req1_op, if1.req0_a, if1.req0_b, if1.req1_a, if1.req1_b} = '0;
    rst0_n = 0;
    rst1_n = 0;
    #1;
    chk("rst_busy", u0.bus.busy, 0);
    chk("rst_valid", if0.rsp_valid, 0);
    chk("rst_sel", if0.alu_select, 0);
    chk("rst_ab", {if0.alu_a, if0.alu_b}, 0);
    chk("rst_rsp", {if0.rsp_id, if0.rsp_x, if0.rsp_zero, if0.rsp_neg, if0.rsp_err}, 0);
    chk("rst1_busy", if1.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst0_n = 1;
    rst1_n = 1;
    // Contention: both requesters always valid, grants must alternate from requester 0.
    if0.rsp_ready = 1;
    if0.req0_op = 4'd8;
    if0.req1_op = 4'd2;
    if0.req0_valid = 1;
    if0.req1_valid = 1;
    for (int c = 0; c < 24; c++) begin
      {if0.req0_a, if0.req0_b, if0.req1_a, if0.req1_b} = $urandom;
      @(posedge clk);
      #1;
    end
    if0.req0_valid = 0;
    if0.req1_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    send0(0, 4'd9, 8'h05, 8'h03);
    repeat (4) @(posedge clk);
    #1;
    for (int c = 0; c < 600; c++) begin
      if0.req0_valid = $urandom_range(0, 1);
      if0.req1_valid = $urandom_range(0, 1);
      if0.req0_op = 4'($urandom_range(0, 15));
      if0.req1_op = 4'($urandom_range(0, 15));
      {if0.req0_a, if0.req0_b, if0.req1_a, if0.req1_b} = $urandom;
      if0.rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    if0.req0_valid = 0;
    if0.req1_valid = 0;
    if0.rsp_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    // Backpressure with a negative result while requester 1 keeps asking.
    if0.rsp_ready = 0;
    send0(0, 4'd0, 8'h80, 8'h11);
    if0.req1_op = 4'd9;
    if0.req1_valid = 1;
    repeat (7) @(posedge clk);
    #1;
    if0.rsp_ready = 1;
    @(posedge clk);
    #1;
    if0.req1_valid = 0;
    repeat (6) @(posedge clk);
    #1;
    send0(1, 4'hC, 8'h12, 8'h34);
    repeat (6) @(posedge clk);
    #1;
    chk("drained", q.size(), 0);
    // Settle time and zero flag on the WAIT_CYCLES=3 instance.
    if1.rsp_ready = 1;
    if1.req0_op = 4'd6;
    if1.req0_a = 8'hFF;
    if1.req0_b = 8'h3C;
    if1.req0_valid = 1;
    @(negedge clk);
    chk("u1_ready0", if1.req0_ready, 1);
    @(posedge clk);
    #1;
    if1.req0_valid = 0;
    wait_rsp1(lat);
    chk("u1_latency", lat, 4);
    chk("u1_x", if1.rsp_x, 8'h00);
    chk("u1_zero", if1.rsp_zero, 1);
    chk("u1_neg", if1.rsp_neg, 0);
    chk("u1_id", if1.rsp_id, 0);
    @(posedge clk);
    #1;
    chk("u1_idle", if1.busy, 0);
    // Reset in the middle of EXEC drops the op and returns the pointer to requester 0.
    if1.req0_op = 4'd9;
    if1.req0_valid = 1;
    @(posedge clk);
    #1;
    if1.req0_valid = 0;
    chk("u1_exec_busy", if1.busy, 1);
    @(posedge clk);
    #2;
    rst1_n = 0;
    #1;
    chk("u1_rst_busy", if1.busy, 0);
    chk("u1_rst_valid", if1.rsp_valid, 0);
    @(posedge clk);
    #1;
    rst1_n = 1;
    if1.req1_op = 4'd9;
    if1.req1_a = 8'h01;
    if1.req1_b = 8'h02;
    if1.req0_valid = 1;
    if1.req1_valid = 1;
    @(negedge clk);
    chk("u1_ptr_r0", if1.req0_ready, 1);
    chk("u1_ptr_r1", if1.req1_ready, 0);
    #1;
    if1.req0_valid = 0;
    #1;
    chk("u1_only_r1", if1.req1_ready, 1);
    @(posedge clk);
    #1;
    if1.req1_valid = 0;
    wait_rsp1(lat);
    chk("u1_r1_latency", lat, 4);
    chk("u1_r1_id", if1.rsp_id, 1);
    chk("u1_r1_x", if1.rsp_x, 8'h03);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
